// File: rtl/stick_encoder.sv
// Joystick front end: 2-flop sync, 5-bit debounce, priority encode, one strobe per press.
// Optional auto-repeat of direction codes when STICK_AUTOREPEAT_EN is defined.
module stick_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 2000,
  parameter int REPEAT_PERIOD   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_press,
  output logic       stick_en,
  output logic [2:0] stick_direction,
  output logic       stick_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, HELD} state_t;

  logic [4:0]    raw, sync1, sync2, cand, deb;
  logic [CW-1:0] cnt;
  logic [2:0]    code;
  state_t        state;

  // Bit order matches priority: press, up, down, left, right.
  assign raw = {btn_press, btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      deb   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        deb <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    code = '1;
    if (deb[4])      code = 3'b100;
    else if (deb[3]) code = 3'b000;
    else if (deb[2]) code = 3'b001;
    else if (deb[1]) code = 3'b010;
    else if (deb[0]) code = 3'b011;
  end

`ifdef STICK_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first, rpt_on;
  logic [4:0]    held_vec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      stick_en        <= 1'b0;
      stick_direction <= '1;
      stick_held      <= 1'b0;
`ifdef STICK_AUTOREPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
      rpt_on    <= 1'b0;
      held_vec  <= '0;
`endif
    end else begin
      stick_en <= 1'b0;
      case (state)
        IDLE: begin
          if (deb != '0) begin
            stick_en        <= 1'b1;
            stick_direction <= code;
            stick_held      <= 1'b1;
            state           <= HELD;
`ifdef STICK_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
            rpt_on    <= (code != 3'b100);
            held_vec  <= deb;
`endif
          end
        end
        HELD: begin
          if (deb == '0) begin
            stick_direction <= '1;
            stick_held      <= 1'b0;
            state           <= IDLE;
`ifdef STICK_AUTOREPEAT_EN
            rpt_cnt <= '0;
            rpt_on  <= 1'b0;
          end else if (deb != held_vec) begin
            // Any change of the held combination latches repeat off until release.
            rpt_cnt <= '0;
            rpt_on  <= 1'b0;
          end else if (rpt_on) begin
            if (rpt_cnt == (rpt_first ? DLY_MAX : PER_MAX)) begin
              stick_en  <= 1'b1;
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stick_encoder.md
Name: stick_encoder

Overview:
- Front-end producer of the joystick event interface (`stick_en`, `stick_direction`) consumed by the machine's menu and config pages.
- Takes five raw, asynchronous, active-high joystick contacts and produces one clean event per press:
  - synchronises the contacts,
  - debounces the 5-bit vector,
  - priority-encodes it,
  - emits a single-cycle `stick_en` pulse with the matching direction code.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced vector updates (≥2).
- REPEAT_DELAY, 2000, hold cycles before the first auto-repeat event (≥2; used only with the optional feature).
- REPEAT_PERIOD, 500, cycles between subsequent auto-repeat events (≥2; used only with the optional feature).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw up contact; asynchronous, active high.
- btn_down  in  1  raw down contact.
- btn_left  in  1  raw left contact.
- btn_right  in  1  raw right contact.
- btn_press  in  1  raw stick-push (select) contact.
- stick_en  out  1  one-cycle event strobe.
- stick_direction  out  3  event code: 000 up, 001 down, 010 left, 011 right, 100 press, 111 idle.
- stick_held  out  1  high while the debounced vector is non-zero.

Behaviour:
- Reset (async assert, sync release):
  - stick_en=0, stick_direction=3'b111, stick_held=0.
  - Sync flops, candidate, debounced vector and all counters cleared; FSM to IDLE.
  - Reset asserted mid-hold or mid-debounce discards everything; no event is emitted on release unless a fresh press is debounced.
- Synchroniser: 2-flop per contact (sync1 → sync2).
- Debounce, every clock edge:
  - If sync2 ≠ cand: cand<=sync2, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: deb<=cand.
  - Else: cnt<=cnt+1.
  - cnt width = clog2(DEBOUNCE_CYCLES); saturates, never wraps.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches deb.
- Priority encode of deb: press > up > down > left > right.
- FSM states: IDLE, HELD.
  - IDLE, deb non-zero: next edge stick_en<=1, stick_direction<=encoded code, stick_held<=1, go to HELD.
  - HELD: stick_en<=0.
  - HELD, deb becomes zero: next edge stick_direction<=111, stick_held<=0, go to IDLE.
  - HELD, deb changes to a different non-zero value (e.g. up → up+right): no event, stick_direction unchanged; the stick must be fully released before the next event.
- Latency: with edge 0 the first edge sampling a stable new raw value into sync1, stick_en is high for exactly the cycle after edge DEBOUNCE_CYCLES+3.
- Release follows the same latency, applied to stick_direction → 111.
- stick_en is never high on two consecutive cycles.
- stick_direction is valid whenever stick_en=1 and holds for the whole hold, so consumers that ignore stick_en still see a stable code.

Optional Feature:
- Macro: STICK_AUTOREPEAT_EN.
- Defined:
  - In HELD with code 000–011, a repeat counter starts at the entry edge.
  - Extra stick_en pulses (same code) are emitted REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while held.
  - Counter clears on release, on reset, and when deb changes; a deb change stops repeating until the stick is released.
  - Code 100 (press) never repeats.
- Undefined: exactly one event per press; repeat counter not present in RTL.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset, then idle → stick_en=0, stick_direction=111, stick_held=0 throughout.
- btn_up held steady from edge 0 → single stick_en pulse in the cycle after edge 7 with stick_direction=000, stick_held=1. Release → stick_direction=111 seven edges after the release is sampled.
- btn_left with 3-cycle bounces (toggling every 3 cycles for 30 cycles), then steady → no event during bouncing; exactly one event (010) after 4 stable cycles plus latency.
- btn_press and btn_down asserted on the same edge → single event code 100.
- Hold btn_down 200 cycles:
  - Macro undefined → exactly 1 pulse.
  - Macro defined → pulses at t0, t0+20, t0+28, t0+36, …, all code 001.
  - Holding btn_press 200 cycles with the macro defined → 1 pulse.
- Hold btn_right, then assert rst_n=0 for 2 cycles mid-hold, then deassert with btn_right still held → outputs reset immediately. After reset release, a new 011 event appears after DEBOUNCE_CYCLES+3 edges; no spurious extra pulse.
